// File: rtl/delay_calibrator.sv
// Measures per-channel arrival skew of a shared calibration pulse, averages it over
// NTRIALS good trials and produces per-channel delay settings that realign the channels.
module delay_calibrator #(
    parameter int NCHAN   = 4,
    parameter int MAXDLY  = 10,
    parameter int DBITS   = 4,
    parameter int NTRIALS = 16,
    parameter int MAXMISS = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [NCHAN-1:0]         i_channels,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_timeout,
    output logic                     o_valid,
    output logic [NCHAN*DBITS-1:0]   o_delays,
    output logic [2:0]               o_dbg_state
);

    localparam int LOG = $clog2(NTRIALS);
    localparam int SW  = DBITS + LOG;
    localparam int TW  = LOG + 1;
    localparam int MW  = $clog2(MAXMISS + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WINDOW  = 3'd2,
        S_ACCUM   = 3'd3,
        S_COMPUTE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [NCHAN-1:0]              r_prev;
    logic [NCHAN-1:0]              r_seen;
    logic [NCHAN-1:0][DBITS-1:0]   r_off;
    logic [NCHAN-1:0][SW-1:0]      r_sum;
    logic [NCHAN-1:0][DBITS-1:0]   r_delays;
    logic [DBITS-1:0]              r_wcnt;
    logic [TW-1:0]                 r_trials;
    logic [MW-1:0]                 r_misses;
    logic                          r_timeout;
    logic                          r_valid;

    logic [NCHAN-1:0]              w_rise;
    logic                          w_abort;
    logic                          w_all_seen;
    logic [TW-1:0]                 w_trials_inc;
    logic [MW-1:0]                 w_misses_inc;
    logic [NCHAN-1:0][DBITS-1:0]   w_mean;
    logic [NCHAN-1:0][DBITS-1:0]   w_new;
    logic [DBITS-1:0]              w_max;

    assign w_rise       = i_channels & ~r_prev;
    assign w_abort      = i_abort && (r_state != S_IDLE);
    assign w_all_seen   = &r_seen;
    assign w_trials_inc = r_trials + TW'(1);
    assign w_misses_inc = r_misses + MW'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_ARM;
            S_ARM:     if (|w_rise) w_next = S_WINDOW;
            S_WINDOW:  if (r_wcnt == DBITS'(MAXDLY - 1)) w_next = S_ACCUM;
            S_ACCUM: begin
                if (w_all_seen)
                    w_next = (w_trials_inc == TW'(NTRIALS)) ? S_COMPUTE : S_ARM;
                else
                    w_next = (w_misses_inc == MW'(MAXMISS)) ? S_IDLE : S_ARM;
            end
            S_COMPUTE: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        // Abort outranks every other transition
        if (w_abort) w_next = S_IDLE;
    end

    // Round-half-up mean per channel, then align everything to the latest channel
    always_comb begin
        w_mean = '0;
        w_new  = '0;
        w_max  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_mean[i] = DBITS'(({1'b0, r_sum[i]} + (SW+1)'(NTRIALS / 2)) >> LOG);
        end
        for (int i = 0; i < NCHAN; i++) begin
            if (w_mean[i] > w_max) w_max = w_mean[i];
        end
        for (int i = 0; i < NCHAN; i++) begin
            w_new[i] = w_max - w_mean[i];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_prev    <= '0;
            r_seen    <= '0;
            r_off     <= '0;
            r_sum     <= '0;
            r_delays  <= '0;
            r_wcnt    <= '0;
            r_trials  <= '0;
            r_misses  <= '0;
            r_timeout <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_prev  <= i_channels;
            if (w_abort) begin
                r_seen <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_sum     <= '0;
                            r_seen    <= '0;
                            r_trials  <= '0;
                            r_misses  <= '0;
                            r_timeout <= 1'b0;
                        end
                    end
                    S_ARM: begin
                        if (|w_rise) begin
                            r_wcnt <= DBITS'(1);
                            for (int i = 0; i < NCHAN; i++) begin
                                if (w_rise[i]) begin
                                    r_off[i]  <= '0;
                                    r_seen[i] <= 1'b1;
                                end
                            end
                        end
                    end
                    S_WINDOW: begin
                        r_wcnt <= r_wcnt + DBITS'(1);
                        for (int i = 0; i < NCHAN; i++) begin
                            if (w_rise[i] && !r_seen[i]) begin
                                r_off[i]  <= r_wcnt;
                                r_seen[i] <= 1'b1;
                            end
                        end
                    end
                    S_ACCUM: begin
                        r_seen <= '0;
                        if (w_all_seen) begin
                            for (int i = 0; i < NCHAN; i++) begin
                                r_sum[i] <= r_sum[i] + SW'(r_off[i]);
                            end
                            r_trials <= w_trials_inc;
                            r_misses <= '0;
                        end else begin
                            r_misses <= w_misses_inc;
                            if (w_misses_inc == MW'(MAXMISS)) r_timeout <= 1'b1;
                        end
                    end
                    S_COMPUTE: begin
                        r_delays <= w_new;
                        r_valid  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_timeout   = r_timeout;
    assign o_valid     = r_valid;
    assign o_delays    = r_delays;
    assign o_dbg_state = r_state;

endmodule
